mult_div_unit: RTL and testbench

- Iterative signed multiply/divide unit for the multicycle MIPS datapath.
- Sits beside the ALU. It consumes the A and B register outputs and produces the HI/LO values for the mult, div, mfhi and mflo instructions.
- The control FSM pulses start, then holds its own state until done.
- HI/LO are held inside this block and read combinationally by the mem-to-reg selector.

---
 rtl/mult_div_unit_pkg.sv | 15 +
 rtl/mult_div_unit_if.sv | 26 ++
 rtl/mult_div_unit_booth_step.sv | 26 ++
 rtl/mult_div_unit.sv | 130 +++++++++++++
 tb/tb_mult_div_unit.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - shared constants and state encoding for the multiply/divide unit
package cpu_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - request/result bundle between control FSM and multiply/divide unit
interface mult_div_if
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, op, a_in, b_in,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, op, a_in, b_in,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/mult_div_unit_booth_step.sv
// rtl/mult_div_unit_booth_step.sv - one radix-2 Booth iteration on {P_hi, P_lo, q_-1}
module booth_step
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2*WIDTH:0] i_acc,
  input  logic [WIDTH-1:0] i_mcand,
  output logic [2*WIDTH:0] o_acc
);
  logic [WIDTH:0] w_hi_ext;
  logic [WIDTH:0] w_m_ext;
  logic [WIDTH:0] w_sum;

  always_comb begin
    w_hi_ext = {i_acc[2*WIDTH], i_acc[2*WIDTH:WIDTH+1]};
    w_m_ext  = {i_mcand[WIDTH-1], i_mcand};
    case (i_acc[1:0])
      2'b01:   w_sum = w_hi_ext + w_m_ext;
      2'b10:   w_sum = w_hi_ext - w_m_ext;
      default: w_sum = w_hi_ext;
    endcase
    // The extra sum bit becomes the new sign, so dropping q_-1 is the arithmetic shift
    o_acc = {w_sum, i_acc[WIDTH:1]};
  end
endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative signed multiply (Booth) / divide (restoring) unit with HI/LO
module mult_div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic       clock,
  input  logic       reset,
  mult_div_if.slave  bus
);
  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_op;
  logic               r_dz;
  logic               r_a_neg;
  logic               r_b_neg;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH:0]   r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_div_zero;

  logic [2*WIDTH:0]   w_booth_acc;
  logic [2*WIDTH:0]   w_div_acc;
  logic [WIDTH:0]     w_rem_shift;
  logic [WIDTH:0]     w_trial;
  logic               w_ge;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic               w_b_zero;

  booth_step #(.WIDTH(WIDTH)) u_booth (
    .i_acc   (r_acc),
    .i_mcand (r_mcand),
    .o_acc   (w_booth_acc)
  );

  always_comb begin
    w_a_mag     = bus.a_in[WIDTH-1] ? -bus.a_in : bus.a_in;
    w_b_mag     = bus.b_in[WIDTH-1] ? -bus.b_in : bus.b_in;
    w_b_zero    = (bus.op == OP_DIV) && (bus.b_in == '0);
    // Divide reuses the accumulator as {rem, quo, unused}
    w_rem_shift = r_acc[2*WIDTH:WIDTH];
    w_ge        = (w_rem_shift >= {1'b0, r_mcand});
    w_trial     = w_rem_shift - {1'b0, r_mcand};
    w_div_acc   = {(w_ge ? w_trial[WIDTH-1:0] : w_rem_shift[WIDTH-1:0]),
                   r_acc[WIDTH-1:1], w_ge, 1'b0};
    w_quo       = r_acc[WIDTH:1];
    w_rem       = r_acc[2*WIDTH:WIDTH+1];
  end

  always_comb begin
    w_state_next = r_state;
    bus.busy     = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: if (bus.start) w_state_next = w_b_zero ? S_FIX : S_CALC;
      S_CALC: if (r_cnt == CNT_W'(WIDTH-1)) w_state_next = S_FIX;
      S_FIX:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_op       <= 1'b0;
      r_dz       <= 1'b0;
      r_a_neg    <= 1'b0;
      r_b_neg    <= 1'b0;
      r_mcand    <= '0;
      r_acc      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_op    <= bus.op;
          r_cnt   <= '0;
          r_dz    <= w_b_zero;
          r_a_neg <= bus.a_in[WIDTH-1];
          r_b_neg <= bus.b_in[WIDTH-1];
          if (bus.op == OP_DIV) begin
            r_mcand <= w_b_mag;
            r_acc   <= {{WIDTH{1'b0}}, w_a_mag, 1'b0};
          end else begin
            r_mcand <= bus.a_in;
            r_acc   <= {{WIDTH{1'b0}}, bus.b_in, 1'b0};
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          r_acc <= (r_op == OP_DIV) ? w_div_acc : w_booth_acc;
        end
        S_FIX: begin
          r_done     <= 1'b1;
          r_div_zero <= r_dz;
          if (!r_dz) begin
            if (r_op == OP_DIV) begin
              r_lo <= (r_a_neg ^ r_b_neg) ? -w_quo : w_quo;
              r_hi <= r_a_neg ? -w_rem : w_rem;
            end else begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.done     = r_done;
  assign bus.div_zero = r_div_zero;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed vector bench for mult_div_unit
module tb_mult_div_unit;
  import cpu_pkg::*;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          edges;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[12];

  mult_div_if #(.WIDTH(32)) bus();

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output logic dz, output int edges, output int busy_n);
    @(negedge clock);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a_in  = a;
    bus.b_in  = b;
    edges  = 0;
    busy_n = 0;
    while (edges < 100) begin
      @(posedge clock);
      edges++;
      #1;
      if (edges == 1) bus.start = 1'b0;
      if (bus.done) break;
      if (bus.busy) busy_n++;
    end
    hi = bus.hi;
    lo = bus.lo;
    dz = bus.div_zero;
  endtask

  initial begin
    logic [31:0] hi, lo;
    logic        dz;
    int          edges, busy_n, ndone, done_edge;

    vecs[0]  = '{OP_MULT, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34};
    vecs[1]  = '{OP_MULT, 32'h80000000,   32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34};
    vecs[2]  = '{OP_DIV,  32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
    vecs[3]  = '{OP_DIV,  32'd100,        32'd7,        32'd2,        32'd14,       1'b0, 34};
    vecs[4]  = '{OP_DIV,  32'h00000692,   32'h20,       32'h12,       32'h34,       1'b0, 34};
    vecs[5]  = '{OP_DIV,  32'd5,          32'd0,        32'h12,       32'h34,       1'b1, 2};
    vecs[6]  = '{OP_DIV,  32'h80000000,   32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
    vecs[7]  = '{OP_MULT, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 34};
    vecs[8]  = '{OP_MULT, 32'h7FFFFFFF,   32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 34};
    vecs[9]  = '{OP_DIV,  32'd7,          32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34};
    vecs[10] = '{OP_DIV,  32'hFFFFFF9C,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0, 34};
    vecs[11] = '{OP_MULT, 32'h80000000,   32'd1,        32'hFFFFFFFF, 32'h80000000, 1'b0, 34};

    bus.start = 1'b0;
    bus.op    = OP_MULT;
    bus.a_in  = '0;
    bus.b_in  = '0;

    repeat (2) @(posedge clock);
    #1;
    check("reset_hi",       bus.hi,       32'h0);
    check("reset_lo",       bus.lo,       32'h0);
    check("reset_busy",     bus.busy,     32'h0);
    check("reset_done",     bus.done,     32'h0);
    check("reset_div_zero", bus.div_zero, 32'h0);
    @(negedge clock);
    reset = 1'b1;

    // Consecutive calls start the next op in the done cycle of the previous one
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, dz, edges, busy_n);
      check($sformatf("v%0d_hi", i),       hi,     vecs[i].hi);
      check($sformatf("v%0d_lo", i),       lo,     vecs[i].lo);
      check($sformatf("v%0d_div_zero", i), dz,     vecs[i].dz);
      check($sformatf("v%0d_edges", i),    edges,  vecs[i].edges);
      check($sformatf("v%0d_busy", i),     busy_n, vecs[i].edges - 1);
    end

    @(negedge clock);
    bus.start = 1'b1;
    bus.op    = OP_MULT;
    bus.a_in  = 32'd3;
    bus.b_in  = 32'd4;
    ndone     = 0;
    done_edge = 0;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clock);
      #1;
      if (i == 1) bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        done_edge = i;
      end
      if (i == 9) begin
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.a_in  = 32'd9;
        bus.b_in  = 32'd3;
      end
      if (i == 10) bus.start = 1'b0;
    end
    check("busy_start_ndone", ndone,     32'd1);
    check("busy_start_edge",  done_edge, 32'd34);
    check("busy_start_hi",    bus.hi,    32'd0);
    check("busy_start_lo",    bus.lo,    32'd12);

    @(negedge clock);
    bus.start = 1'b1;
    bus.op    = OP_DIV;
    bus.a_in  = 32'd100;
    bus.b_in  = 32'd7;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clock);
      #1;
      if (i == 1) bus.start = 1'b0;
    end
    #2;
    reset = 1'b0;
    #1;
    check("abort_hi",       bus.hi,       32'h0);
    check("abort_lo",       bus.lo,       32'h0);
    check("abort_busy",     bus.busy,     32'h0);
    check("abort_done",     bus.done,     32'h0);
    check("abort_div_zero", bus.div_zero, 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    run_op(OP_MULT, 32'd5, 32'd6, hi, lo, dz, edges, busy_n);
    check("post_reset_hi",    hi,    32'd0);
    check("post_reset_lo",    lo,    32'd30);
    check("post_reset_edges", edges, 32'd34);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
